// File: rtl/shift_reg_param.sv
// Parameterised shift/rotate/load register with counted multi-step operations.
// A small IDLE/BUSY/DONE controller sequences counted runs of shift, rotate or arithmetic steps.
module shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CW-1:0]    cnt,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] MODE_LSH  = 3'b001;
  localparam logic [2:0] MODE_ROT  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ASH  = 3'b100;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             out_valid;
    logic             out_bit;
  } step_t;

  // One step of an operation; out_valid marks steps that move a bit out of the register.
  function automatic step_t do_step(input logic [2:0] m, input logic dr, input logic si,
                                    input logic [WIDTH-1:0] cur, input logic [WIDTH-1:0] ld);
    step_t r;
    r.q         = cur;
    r.out_valid = 1'b0;
    r.out_bit   = dr ? cur[0] : cur[WIDTH-1];
    case (m)
      MODE_LSH: begin
        r.q         = dr ? {si, cur[WIDTH-1:1]} : {cur[WIDTH-2:0], si};
        r.out_valid = 1'b1;
      end
      MODE_ROT: begin
        r.q         = dr ? {cur[0], cur[WIDTH-1:1]} : {cur[WIDTH-2:0], cur[WIDTH-1]};
        r.out_valid = 1'b1;
      end
      MODE_ASH: begin
        r.q         = dr ? {cur[WIDTH-1], cur[WIDTH-1:1]} : {cur[WIDTH-2:0], 1'b0};
        r.out_valid = 1'b1;
      end
      MODE_LOAD: r.q = ld;
      default:   r.q = cur;
    endcase
    return r;
  endfunction

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [2:0]       op_mode, op_mode_nxt;
  logic             op_dir, op_dir_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             s_out_nxt;
  step_t            step_free, step_busy;
  logic             counted;

  assign step_free = do_step(mode, dir, s_in, q, d);
  assign step_busy = do_step(op_mode, op_dir, s_in, q, d);
  assign counted   = (mode == MODE_LSH) || (mode == MODE_ROT) || (mode == MODE_ASH);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    op_mode_nxt = op_mode;
    op_dir_nxt  = op_dir;
    q_nxt       = q;
    s_out_nxt   = s_out;
    case (state)
      IDLE: begin
        if (enb) begin
          if (start && counted) begin
            op_mode_nxt = mode;
            op_dir_nxt  = dir;
            count_nxt   = cnt;
            state_nxt   = (cnt == '0) ? DONE : BUSY;
          end else begin
            q_nxt = step_free.q;
            if (step_free.out_valid) s_out_nxt = step_free.out_bit;
          end
        end
      end
      BUSY: begin
        if (enb) begin
          q_nxt     = step_busy.q;
          s_out_nxt = step_busy.out_bit;
          count_nxt = count - 1'b1;
          if (count == CW'(1)) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      op_mode <= 3'b000;
      op_dir  <= 1'b0;
      q       <= '0;
      s_out   <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      op_mode <= op_mode_nxt;
      op_dir  <= op_dir_nxt;
      q       <= q_nxt;
      s_out   <= s_out_nxt;
    end
  end

  assign busy = (state == BUSY);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_reg_param.sv
// Self-checking bench for shift_reg_param (WIDTH=8, CW=4): vector table, counted-op
// sequences and asynchronous reset cases, with a queue of expected results per edge.
module tb_shift_reg_param;

  logic       clk = 1'b0;
  logic       rst, enb, dir, s_in, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] cnt;
  logic [7:0] q;
  logic       s_out, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  shift_reg_param #(.WIDTH(8), .CW(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .dir(dir), .s_in(s_in), .mode(mode),
    .d(d), .start(start), .cnt(cnt), .q(q), .s_out(s_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       enb, start;
    logic [2:0] mode;
    logic       dir, s_in;
    logic [7:0] d;
    logic [3:0] cnt;
    logic [7:0] exp_q;
    logic       exp_s;
  } vec_t;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       s_out, busy, done;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic e, input logic st, input logic [2:0] m, input logic dr,
                       input logic si, input logic [7:0] dd, input logic [3:0] c);
    enb = e; start = st; mode = m; dir = dr; s_in = si; d = dd; cnt = c;
  endtask

  // Queue the expected outputs, take one clock edge, then compare what the DUT produced.
  task automatic cycle(input string tag, input logic [7:0] eq, input logic es,
                       input logic eb, input logic ed);
    exp_t e;
    e.tag = tag; e.q = eq; e.s_out = es; e.busy = eb; e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, " q"}, 32'(q), 32'(e.q));
    check({e.tag, " s_out/busy/done"}, 32'({s_out, busy, done}), 32'({e.s_out, e.busy, e.done}));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " q"}, 32'(q), 32'h00);
    check({tag, " s_out/busy/done"}, 32'({s_out, busy, done}), 32'b000);
  endtask

  initial begin
    // enb start mode dir s_in d cnt -> q s_out
    vecs[0]  = '{1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 8'hA5, 4'd0, 8'hA5, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b1, 8'h00, 4'd0, 8'h4B, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 8'h00, 4'd0, 8'h25, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 8'h00, 4'd0, 8'h92, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 8'h00, 4'd0, 8'h25, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 8'h00, 4'd0, 8'h4A, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'hFF, 4'd0, 8'h4A, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 3'b101, 1'b1, 1'b1, 8'hFF, 4'd3, 8'h4A, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'b011, 1'b0, 1'b0, 8'h81, 4'd2, 8'h81, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 1'b0, 1'b0, 8'h00, 4'd0, 8'h03, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 8'h00, 4'd0, 8'h03, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 8'h00, 4'd0, 8'h01, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 8'h00, 4'd0, 8'h80, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 8'h00, 4'd0, 8'hC0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 4'd0);
    #2;
    check_reset_state("power-on reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Free-run single steps from the table
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].enb, vecs[i].start, vecs[i].mode, vecs[i].dir, vecs[i].s_in, vecs[i].d, vecs[i].cnt);
      cycle($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_s, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges
    #1 rst = 1'b1;
    #1 check_reset_state("async reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Counted arithmetic right shift by 3, mode/dir/start changes during BUSY ignored
    drive(1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 8'h96, 4'd0);
    cycle("load 96", 8'h96, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 4'd3);
    cycle("asr start", 8'h96, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 4'd7);
    cycle("asr step1", 8'hCB, 1'b0, 1'b1, 1'b0);
    cycle("asr step2", 8'hE5, 1'b1, 1'b1, 1'b0);
    cycle("asr step3", 8'hF2, 1'b1, 1'b0, 1'b1);
    cycle("asr idle", 8'hF2, 1'b1, 1'b0, 1'b0);

    // Same operation with enb low for two cycles mid-BUSY
    drive(1'b1, 1'b0, 3'b011, 1'b0, 1'b0, 8'h96, 4'd0);
    cycle("reload 96", 8'h96, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 4'd3);
    cycle("stall start", 8'h96, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 4'd0);
    cycle("stall step1", 8'hCB, 1'b0, 1'b1, 1'b0);
    enb = 1'b0;
    cycle("stall hold1", 8'hCB, 1'b0, 1'b1, 1'b0);
    cycle("stall hold2", 8'hCB, 1'b0, 1'b1, 1'b0);
    enb = 1'b1;
    cycle("stall step2", 8'hE5, 1'b1, 1'b1, 1'b0);
    cycle("stall step3", 8'hF2, 1'b1, 1'b0, 1'b1);
    enb = 1'b0;
    cycle("stall done->idle", 8'hF2, 1'b1, 1'b0, 1'b0);

    // cnt=0 goes straight to DONE without stepping
    drive(1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 8'h00, 4'd0);
    cycle("cnt0 done", 8'hF2, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 8'h00, 4'd0);
    cycle("cnt0 idle", 8'hF2, 1'b1, 1'b0, 1'b0);

    // Reset during BUSY aborts the operation with no later done pulse
    drive(1'b1, 1'b1, 3'b001, 1'b0, 1'b1, 8'h00, 4'd5);
    cycle("abort start", 8'hF2, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 8'h00, 4'd0);
    cycle("abort step1", 8'hE5, 1'b1, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 check_reset_state("abort reset");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle($sformatf("abort after%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
